bist_resp_analyzer: RTL and testbench

BIST_RESP_ANALYZER -- requirements
Module: bist_resp_analyzer

---
 rtl/bist_resp_analyzer.sv | 165 ++++++++++++++++
 tb/tb_bist_resp_analyzer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bist_resp_analyzer.sv
// -----------------------------------------------------------------------------
// bist_resp_analyzer
//   BIST response analyzer. A 16-bit MISR (x^16+x^12+x^5+1) compacts the CUT
//   response between INIT and FINISH pulses from the BIST controller. On
//   FINISH the signature is compared against GOLDEN, and a PASS/FAIL verdict
//   is held with DONE until the next INIT or reset. Out-of-sequence controller
//   activity raises a sticky protocol error.
//
//   Optional feature: define BIST_RA_CYCLE_CHECK_EN to add an 8-bit saturating
//   count of compacted cycles. PASS then also requires count == EXP_CYCLES.
//   Without the macro, the counter is not built.
//
// Parameters
//   DW          width of data_in (at most 16; zero-extended into the MISR)
//   SEED        MISR value loaded on init
//   GOLDEN      expected final signature
//   EXP_CYCLES  expected number of compacted cycles (cycle-check build only)
//
// Ports
//   clk        clock; all state changes on its rising edge
//   reset      asynchronous active-high reset
//   init       one-cycle pulse that starts a test
//   running    data_in is valid for compaction this cycle
//   finish     one-cycle pulse that ends a test
//   data_in    CUT response
//   signature  registered MISR contents
//   done       a verdict is held
//   pass       verdict good (meaningful only while done)
//   fail       verdict bad (meaningful only while done)
//   proto_err  sticky sequence-violation flag, cleared by init or reset
// -----------------------------------------------------------------------------
module bist_resp_analyzer #(
   parameter int unsigned DW         = 8,
   parameter logic [15:0] SEED       = 16'h0000,
   parameter logic [15:0] GOLDEN     = 16'h0000,
   parameter logic [7:0]  EXP_CYCLES = 8'd90
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          init,
   input  logic          running,
   input  logic          finish,
   input  logic [DW-1:0] data_in,
   output logic [15:0]   signature,
   output logic          done,
   output logic          pass,
   output logic          fail,
   output logic          proto_err
);

   typedef enum logic [1:0] {IDLE, ARMED, COMPACT, DONE_S} state_t;

   state_t      state, state_d;
   logic [15:0] sig_d;
   logic        done_d, pass_d, fail_d, proto_d;
   logic        active;
   logic        verdict;
   logic [15:0] d_ext;

   // One MISR step: shift left, feed s[15] back into taps 0, 5 and 12, XOR data.
   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
      logic [15:0] n;
      n[0] = s[15] ^ d[0];
      for (int i = 1; i < 16; i++) begin
         n[i] = s[i-1] ^ d[i];
      end
      n[5]  = n[5]  ^ s[15];
      n[12] = n[12] ^ s[15];
      return n;
   endfunction

   assign d_ext  = 16'(data_in);
   // ARMED and COMPACT behave identically apart from the state name.
   assign active = (state == ARMED) || (state == COMPACT);

`ifdef BIST_RA_CYCLE_CHECK_EN
   logic [7:0] count, count_d;

   always_comb begin
      count_d = count;
      if (init) begin
         count_d = 8'd0;
      end else if (!finish && active && running && count != 8'hFF) begin
         count_d = count + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count <= 8'd0;
      else       count <= count_d;
   end

   assign verdict = (signature == GOLDEN) && (count == EXP_CYCLES);
`else
   assign verdict = (signature == GOLDEN);
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   // Next-state logic: init always wins, any finish lands in DONE_S.
   always_comb begin
      state_d = state;
      if (init) begin
         state_d = ARMED;
      end else if (finish) begin
         state_d = DONE_S;
      end else if (state == ARMED && running) begin
         state_d = COMPACT;
      end
   end

   // Output / datapath next values.
   // NOTE: every signal gets a hold default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      sig_d   = signature;
      done_d  = done;
      pass_d  = pass;
      fail_d  = fail;
      proto_d = proto_err;
      if (init) begin
         sig_d   = SEED;
         done_d  = 1'b0;
         pass_d  = 1'b0;
         fail_d  = 1'b0;
         proto_d = finish;            // init+finish together is a violation
      end else if (finish) begin
         done_d = 1'b1;
         if (active && !running) begin
            pass_d = verdict;
            fail_d = !verdict;
         end else begin
            // Finish outside a test, or finish colliding with running data.
            pass_d  = 1'b0;
            fail_d  = 1'b1;
            proto_d = 1'b1;
         end
      end else if (active && running) begin
         sig_d = misr_step(signature, d_ext);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         signature <= 16'h0000;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         signature <= sig_d;
         done      <= done_d;
         pass      <= pass_d;
         fail      <= fail_d;
         proto_err <= proto_d;
      end
   end

endmodule

// File: tb/tb_bist_resp_analyzer.sv
// -----------------------------------------------------------------------------
// tb_bist_resp_analyzer
//   The stimulus process drives controller activity and updates a behavioural
//   model of the analyzer. For every init or finish pulse, it pushes the
//   expected outputs onto a queue. A separate monitor pops one entry at each
//   falling edge that follows such a pulse and compares it. The model tracks
//   only whether a test is active, the signature, and the count, and it
//   advances the MISR with the Galois-form arithmetic (s<<1 ^ 0x1021).
// -----------------------------------------------------------------------------
module tb_bist_resp_analyzer;

   localparam int unsigned DW         = 8;
   localparam logic [15:0] SEED       = 16'h0000;
   localparam logic [15:0] GOLDEN     = 16'h0000;
   localparam int          EXP_CYCLES = 90;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          init = 1'b0;
   logic          running = 1'b0;
   logic          finish = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [15:0]   signature;
   logic          done, pass, fail, proto_err;

   bist_resp_analyzer #(
      .DW(DW), .SEED(SEED), .GOLDEN(GOLDEN), .EXP_CYCLES(8'(EXP_CYCLES))
   ) dut (
      .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
      .data_in(data_in), .signature(signature), .done(done), .pass(pass),
      .fail(fail), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] sig;
      logic        done;
      logic        pass;
      logic        fail;
      logic        proto;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Behavioural model state.
   int unsigned m_sig    = 0;
   int          m_cnt    = 0;
   bit          m_active = 0;
   bit          m_done = 0, m_pass = 0, m_fail = 0, m_proto = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sig = 0; m_cnt = 0; m_active = 0;
      m_done = 0; m_pass = 0; m_fail = 0; m_proto = 0;
   endtask

   task automatic model_step(input bit i, input bit r, input bit f, input int unsigned d);
      bit good;
      if (i) begin
         m_sig = SEED; m_cnt = 0; m_active = 1;
         m_done = 0; m_pass = 0; m_fail = 0; m_proto = f;
      end else if (f) begin
         m_done = 1;
         if (m_active && !r) begin
            good = (m_sig == GOLDEN);
`ifdef BIST_RA_CYCLE_CHECK_EN
            good = good && (m_cnt == EXP_CYCLES);
`endif
            m_pass = good; m_fail = !good;
         end else begin
            m_pass = 0; m_fail = 1; m_proto = 1;
         end
         m_active = 0;
      end else if (r && m_active) begin
         m_sig = ((m_sig << 1) ^ ((m_sig & 32'h8000) != 0 ? 32'h1021 : 32'h0) ^ d) & 32'hFFFF;
         if (m_cnt < 255) m_cnt++;
      end
   endtask

   // Drive one clock cycle of controller activity, then return at posedge+1.
   task automatic drive(input bit i, input bit r, input bit f, input logic [DW-1:0] d);
      init = i; running = r; finish = f; data_in = d;
      model_step(i, r, f, 32'(d));
      if (i || f) exp_q.push_back('{16'(m_sig), m_done, m_pass, m_fail, m_proto});
      @(posedge clk);
      #1;
      init = 0; running = 0; finish = 0; data_in = '0;
   endtask

   // Monitor: one expected entry per init/finish pulse, compared after the edge.
   logic ev_q = 1'b0;
   always @(posedge clk) ev_q <= (init || finish) && !reset;

   always @(negedge clk) begin
      if (ev_q) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_underflow: output event with no expected entry at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_signature", 32'(signature), 32'(e.sig));
            check("sb_done",      32'(done),      32'(e.done));
            check("sb_pass",      32'(pass),      32'(e.pass));
            check("sb_fail",      32'(fail),      32'(e.fail));
            check("sb_proto_err", 32'(proto_err), 32'(e.proto));
            check("sb_not_both",  32'(pass && fail), 32'(0));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_signature"}, 32'(signature), 32'h0);
      check({tag, "_done"},      32'(done),      32'h0);
      check({tag, "_pass"},      32'(pass),      32'h0);
      check({tag, "_fail"},      32'(fail),      32'h0);
      check({tag, "_proto_err"}, 32'(proto_err), 32'h0);
   endtask

   task automatic rand_test();
      int n;
      bit zero_data;
      int sel;
      n = $urandom_range(0, 120);
      zero_data = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) drive(0, 1, 0, DW'($urandom));  // stray running
      drive(1, 0, ($urandom_range(0, 9) == 0), '0);
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 4) == 0) drive(0, 0, 0, DW'($urandom));
         drive(0, 1, 0, zero_data ? '0 : DW'($urandom));
      end
      sel = $urandom_range(0, 9);
      if (sel == 0) drive(0, 1, 1, DW'($urandom));
      else          drive(0, 0, 1, '0);
      if ($urandom_range(0, 4) == 0) drive(0, 0, 1, '0);             // finish in DONE_S
      for (int k = 0; k < 2; k++) drive(0, $urandom_range(0, 1) == 1, 0, DW'($urandom));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, asserted before any clock edge.
      #3;
      check_all_zero("reset");
      @(posedge clk);
      #1 reset = 0;
      model_reset();
      @(posedge clk);
      #1;

      // Finish without init after reset, then an init clears the flags.
      drive(0, 0, 1, '0);
      drive(1, 0, 0, '0);

      // 90 zero cycles, then finish: pass.
      for (int k = 0; k < 90; k++) drive(0, 1, 0, '0);
      drive(0, 0, 1, '0);

      // 89 zero cycles: the verdict depends on the cycle-check build.
      drive(1, 0, 0, '0);
      for (int k = 0; k < 89; k++) drive(0, 1, 0, '0);
      drive(0, 0, 1, '0);

      // A single 0x01 gives signature 0x0001, which is not GOLDEN.
      drive(1, 0, 0, '0);
      drive(0, 1, 0, 8'h01);
      check("sig_0001", 32'(signature), 32'h0001);
      drive(0, 0, 1, '0);

      // 0x80 then eight zeros gives 0x8000, and one more zero cycle gives 0x1021.
      drive(1, 0, 0, '0);
      drive(0, 1, 0, 8'h80);
      for (int k = 0; k < 8; k++) drive(0, 1, 0, '0);
      check("sig_8000", 32'(signature), 32'h8000);
      drive(0, 1, 0, '0);
      check("sig_1021", 32'(signature), 32'h1021);
      drive(0, 0, 0, '0);
      check("sig_hold", 32'(signature), 32'h1021);
      drive(0, 1, 1, 8'h5A);                       // running+finish collision

      // Init and finish in the same cycle.
      drive(1, 0, 1, '0);
      drive(0, 0, 1, '0);

      // Saturating count: 300 zero cycles.
      drive(1, 0, 0, '0);
      for (int k = 0; k < 300; k++) drive(0, 1, 0, '0);
      drive(0, 0, 1, '0);

      // Asynchronous reset during compaction, at cycle 40.
      drive(1, 0, 0, '0);
      for (int k = 0; k < 40; k++) drive(0, 1, 0, DW'($urandom));
      #2 reset = 1;
      #1 check_all_zero("midrun_reset");
      model_reset();
      #2 reset = 0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) drive(0, 1, 0, DW'($urandom));
      check("idle_running_ignored", 32'(signature), 32'h0);
      drive(0, 0, 1, '0);
      drive(1, 0, 0, '0);

      // Randomised tests.
      for (int t = 0; t < 40; t++) rand_test();

      for (int k = 0; k < 3; k++) drive(0, 0, 0, '0);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
